cache_refill_sequencer: RTL and testbench

Miss-service sequencer between the cache controller and main memory. It accepts one miss at a time from the controller. If the victim line is dirty, it first writes that line back, then fetches the requested block. It returns the fetched block to the controller with a one-cycle valid strobe. A wait-cycle watchdog aborts a memory transaction that is never acknowledged.

---
 rtl/cache_refill_sequencer.sv | 167 ++++++++++++++++
 tb/tb_cache_refill_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_sequencer.sv
// Miss-service sequencer: optional dirty-victim write-back, then block fetch.
// Ports: missValid/missReady handshake with miss and victim info in;
//   memReq/memWrite/memAddress/writeBackData out, memAck/memReadData in;
//   fetchedData/fetchAddress with refillValid/refillError strobes; busy.
module cache_refill_sequencer #(
   parameter int BLOCK_SIZE    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int COUNTER_WIDTH = 8,
   parameter int MAX_WAIT      = 200
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     missValid,
   output logic                     missReady,
   input  logic [ADDRESS_WIDTH-1:0] missAddress,
   input  logic                     victimDirty,
   input  logic [ADDRESS_WIDTH-1:0] victimAddress,
   input  logic [8*BLOCK_SIZE-1:0]  victimData,
   output logic                     memReq,
   output logic                     memWrite,
   output logic [ADDRESS_WIDTH-1:0] memAddress,
   output logic [8*BLOCK_SIZE-1:0]  writeBackData,
   input  logic                     memAck,
   input  logic [8*BLOCK_SIZE-1:0]  memReadData,
   output logic [8*BLOCK_SIZE-1:0]  fetchedData,
   output logic [ADDRESS_WIDTH-1:0] fetchAddress,
   output logic                     refillValid,
   output logic                     refillError,
   output logic                     busy
);

   localparam int LINE_W = 8 * BLOCK_SIZE;

   // Clears the byte-offset bits to get a block base address.
   localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
      ~(ADDRESS_WIDTH'(BLOCK_SIZE - 1));

   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(MAX_WAIT);
   localparam logic [COUNTER_WIDTH-1:0] CNT_SAT = '1;
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      FETCH_REQ,
      RESPOND,
      ERROR
   } state_t;

   state_t                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [COUNTER_WIDTH-1:0] cnt_inc;
   logic                     timeout;
   logic [ADDRESS_WIDTH-1:0] miss_addr_q, miss_addr_d;
   logic [ADDRESS_WIDTH-1:0] vic_addr_q, vic_addr_d;
   logic [LINE_W-1:0]        vic_data_q, vic_data_d;
   logic [LINE_W-1:0]        fetched_data_q, fetched_data_d;
   logic [ADDRESS_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                     mem_req_q, mem_req_d;
   logic                     mem_write_q, mem_write_d;
   logic                     refill_valid_q, refill_valid_d;
   logic                     refill_error_q, refill_error_d;
   logic                     miss_ready_q, miss_ready_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      miss_addr_d    = miss_addr_q;
      vic_addr_d     = vic_addr_q;
      vic_data_d     = vic_data_q;
      fetched_data_d = fetched_data_q;
      fetch_addr_d   = fetch_addr_q;

      // Saturating increment; an ack in the limit cycle still wins.
      cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
      timeout = !memAck && (cnt_inc >= CNT_MAX);

      unique case (state_q)
         IDLE: begin
            if (missValid) begin
               miss_addr_d = missAddress & ALIGN_MASK;
               vic_addr_d  = victimAddress & ALIGN_MASK;
               vic_data_d  = victimData;
               cnt_d       = '0;
               state_d     = victimDirty ? WB_REQ : FETCH_REQ;
            end
         end
         WB_REQ: begin
            if (memAck) begin
               cnt_d   = '0;
               state_d = FETCH_REQ;
            end else begin
               cnt_d = cnt_inc;
               if (timeout) state_d = ERROR;
            end
         end
         FETCH_REQ: begin
            if (memAck) begin
               fetched_data_d = memReadData;
               fetch_addr_d   = miss_addr_q;
               cnt_d          = '0;
               state_d        = RESPOND;
            end else begin
               cnt_d = cnt_inc;
               if (timeout) state_d = ERROR;
            end
         end
         RESPOND: state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they leave a flop.
      mem_req_d      = (state_d == WB_REQ) || (state_d == FETCH_REQ);
      mem_write_d    = (state_d == WB_REQ);
      mem_addr_d     = (state_d == WB_REQ)    ? vic_addr_d  :
                       (state_d == FETCH_REQ) ? miss_addr_d : '0;
      refill_valid_d = (state_d == RESPOND);
      refill_error_d = (state_d == ERROR);
      miss_ready_d   = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         miss_addr_q    <= '0;
         vic_addr_q     <= '0;
         vic_data_q     <= '0;
         fetched_data_q <= '0;
         fetch_addr_q   <= '0;
         mem_addr_q     <= '0;
         mem_req_q      <= 1'b0;
         mem_write_q    <= 1'b0;
         refill_valid_q <= 1'b0;
         refill_error_q <= 1'b0;
         miss_ready_q   <= 1'b1;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         miss_addr_q    <= miss_addr_d;
         vic_addr_q     <= vic_addr_d;
         vic_data_q     <= vic_data_d;
         fetched_data_q <= fetched_data_d;
         fetch_addr_q   <= fetch_addr_d;
         mem_addr_q     <= mem_addr_d;
         mem_req_q      <= mem_req_d;
         mem_write_q    <= mem_write_d;
         refill_valid_q <= refill_valid_d;
         refill_error_q <= refill_error_d;
         miss_ready_q   <= miss_ready_d;
      end
   end

   assign missReady     = miss_ready_q;
   assign busy          = ~miss_ready_q;
   assign memReq        = mem_req_q;
   assign memWrite      = mem_write_q;
   assign memAddress    = mem_addr_q;
   assign writeBackData = vic_data_q;
   assign fetchedData   = fetched_data_q;
   assign fetchAddress  = fetch_addr_q;
   assign refillValid   = refill_valid_q;
   assign refillError   = refill_error_q;

endmodule

// File: tb/tb_cache_refill_sequencer.sv
// Bench for cache_refill_sequencer: queue-based reference model,
// per-cycle output compare, directed scenarios and random misses.
module tb_cache_refill_sequencer;

   localparam int AW = 32;
   localparam int LW = 256;
   localparam int MW = 200;
   localparam logic [AW-1:0] MASK = 32'hFFFF_FFE0;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          missValid = 1'b0;
   logic          missReady;
   logic [AW-1:0] missAddress = '0;
   logic          victimDirty = 1'b0;
   logic [AW-1:0] victimAddress = '0;
   logic [LW-1:0] victimData = '0;
   logic          memReq;
   logic          memWrite;
   logic [AW-1:0] memAddress;
   logic [LW-1:0] writeBackData;
   logic          memAck = 1'b0;
   logic [LW-1:0] memReadData = '0;
   logic [LW-1:0] fetchedData;
   logic [AW-1:0] fetchAddress;
   logic          refillValid;
   logic          refillError;
   logic          busy;

   cache_refill_sequencer dut (
      .clk(clk), .reset(reset),
      .missValid(missValid), .missReady(missReady),
      .missAddress(missAddress), .victimDirty(victimDirty),
      .victimAddress(victimAddress), .victimData(victimData),
      .memReq(memReq), .memWrite(memWrite),
      .memAddress(memAddress), .writeBackData(writeBackData),
      .memAck(memAck), .memReadData(memReadData),
      .fetchedData(fetchedData), .fetchAddress(fetchAddress),
      .refillValid(refillValid), .refillError(refillError),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [LW-1:0] act,
                      input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_to(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference model: a miss becomes a queue of memory transactions.
   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
   } tx_t;

   tx_t           mq[$];
   int            m_wait = 0;
   bit            m_rv = 0;
   bit            m_re = 0;
   logic [LW-1:0] m_fd = '0;
   logic [AW-1:0] m_fa = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_wait = 0;
         m_rv = 0;
         m_re = 0;
         m_fd = '0;
         m_fa = '0;
      end else begin
         bit idle;
         idle = (mq.size() == 0) && !m_rv && !m_re;
         m_rv = 0;
         m_re = 0;
         if (idle) begin
            if (missValid) begin
               if (victimDirty)
                  mq.push_back('{1'b1, victimAddress & MASK, victimData});
               mq.push_back('{1'b0, missAddress & MASK, '0});
               m_wait = 0;
            end
         end else if (mq.size() > 0) begin
            if (memAck) begin
               if (!mq[0].wr) begin
                  m_fd = memReadData;
                  m_fa = mq[0].addr;
                  m_rv = 1;
               end
               void'(mq.pop_front());
               m_wait = 0;
            end else begin
               m_wait++;
               if (m_wait >= MW) begin
                  mq.delete();
                  m_re = 1;
               end
            end
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      bit req_e;
      bit act_e;
      req_e = mq.size() > 0;
      act_e = req_e || m_rv || m_re;
      chk("memReq", memReq, req_e);
      if (req_e) begin
         chk("memWrite", memWrite, mq[0].wr);
         chk("memAddress", memAddress, mq[0].addr);
         if (mq[0].wr) chk("writeBackData", writeBackData, mq[0].data);
      end
      chk("refillValid", refillValid, m_rv);
      chk("refillError", refillError, m_re);
      chk("missReady", missReady, !act_e);
      chk("busy", busy, act_e);
      chk("fetchedData", fetchedData, m_fd);
      chk("fetchAddress", fetchAddress, m_fa);
   end

   // Memory responder. mode 0: ack after a per-kind delay,
   // mode 1: ack held high, mode 2: never ack.
   int            ack_mode = 0;
   int            wb_dly = 0;
   int            rd_dly = 0;
   int            wcnt = 0;
   bit            idle_noise = 0;
   bit            rand_data = 0;
   logic [LW-1:0] rd_pat = '0;

   always @(negedge clk) begin
      memReadData = rand_data ? rnd_line() : rd_pat;
      if (ack_mode == 1) begin
         memAck = 1'b1;
      end else if (memReq && ack_mode == 0) begin
         memAck = (wcnt == (memWrite ? wb_dly : rd_dly));
         wcnt = memAck ? 0 : wcnt + 1;
      end else begin
         memAck = (ack_mode == 0) && !memReq && idle_noise &&
                  ($urandom_range(3) == 0);
         wcnt = 0;
      end
   end

   // One miss; returns negedge index of the strobe and the first-cycle
   // request outputs.
   task automatic do_miss(input bit d, input logic [AW-1:0] ma,
                          input logic [AW-1:0] va, input logic [LW-1:0] vd,
                          output int lat, output bit err,
                          output bit p_req, output bit p_wr,
                          output logic [AW-1:0] p_addr,
                          output logic [LW-1:0] p_wbd);
      int g;
      g = 0;
      lat = 0;
      err = 0;
      while (!missReady && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (!missReady) begin
         fail_to("missReady");
         return;
      end
      missValid = 1'b1;
      victimDirty = d;
      missAddress = ma;
      victimAddress = va;
      victimData = vd;
      @(negedge clk);
      missValid = 1'b0;
      missAddress = $urandom;
      victimAddress = $urandom;
      victimDirty = 1'($urandom);
      victimData = rnd_line();
      p_req = memReq;
      p_wr = memWrite;
      p_addr = memAddress;
      p_wbd = writeBackData;
      lat = 1;
      while (!(refillValid || refillError) && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      if (!(refillValid || refillError)) fail_to("refill strobe");
      err = refillError;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global: simulation time limit");
      $fatal(1);
   end

   initial begin
      logic [LW-1:0] pat_a, pat_b, pat_c;
      int            lat;
      bit            err, p_req, p_wr;
      logic [AW-1:0] p_addr;
      logic [LW-1:0] p_wbd;
      int            rv_k[$];
      logic [AW-1:0] rv_a[$];

      pat_a = {8{32'hA5A5_0001}};
      pat_b = {8{32'hB0B0_0002}};
      pat_c = {8{32'hC3C3_0003}};

      @(negedge clk);
      chk("rst missReady", missReady, 1'b1);
      chk("rst memReq", memReq, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst refillValid", refillValid, 1'b0);
      chk("rst fetchedData", fetchedData, '0);
      chk("rst writeBackData", writeBackData, '0);
      reset = 1'b0;
      @(negedge clk);

      // Clean miss, ack 3 cycles after request.
      ack_mode = 0; rd_dly = 3; rd_pat = pat_a;
      do_miss(0, 32'h0000_1234, 32'h0, '0, lat, err, p_req, p_wr, p_addr, p_wbd);
      chk("t1 req", p_req, 1'b1);
      chk("t1 write", p_wr, 1'b0);
      chk("t1 addr", p_addr, 32'h0000_1220);
      chk("t1 latency", lat, 5);
      chk("t1 err", err, 1'b0);
      chk("t1 data", fetchedData, pat_a);
      chk("t1 faddr", fetchAddress, 32'h0000_1220);
      @(negedge clk);
      chk("t1 ready after", missReady, 1'b1);

      // No ack: watchdog abort, fetched line untouched.
      ack_mode = 2;
      do_miss(0, 32'h0000_5000, 32'h0, '0, lat, err, p_req, p_wr, p_addr, p_wbd);
      chk("t4 latency", lat, MW + 1);
      chk("t4 err", err, 1'b1);
      chk("t4 memReq", memReq, 1'b0);
      chk("t4 data kept", fetchedData, pat_a);
      @(negedge clk);
      chk("t4 idle", missReady, 1'b1);

      // Ack in the last allowed cycle completes normally.
      ack_mode = 0; rd_dly = MW - 1; rd_pat = pat_c;
      do_miss(0, 32'h0000_6010, 32'h0, '0, lat, err, p_req, p_wr, p_addr, p_wbd);
      chk("t4b latency", lat, MW + 1);
      chk("t4b err", err, 1'b0);
      chk("t4b data", fetchedData, pat_c);
      @(negedge clk);

      // Dirty miss, acks at 2 and 4.
      wb_dly = 2; rd_dly = 4; rd_pat = pat_a;
      do_miss(1, 32'h0000_2040, 32'h0000_8000, pat_b,
              lat, err, p_req, p_wr, p_addr, p_wbd);
      chk("t2 wr", p_wr, 1'b1);
      chk("t2 wr addr", p_addr, 32'h0000_8000);
      chk("t2 wb data", p_wbd, pat_b);
      chk("t2 latency", lat, 9);
      chk("t2 faddr", fetchAddress, 32'h0000_2040);
      @(negedge clk);

      // Zero-wait memory, ack held high.
      ack_mode = 1; rd_pat = pat_b;
      repeat (3) @(negedge clk);
      do_miss(0, 32'h0000_0100, 32'h0, '0, lat, err, p_req, p_wr, p_addr, p_wbd);
      chk("t3 clean latency", lat, 2);
      do_miss(1, 32'h0000_0200, 32'h0000_0340, pat_c,
              lat, err, p_req, p_wr, p_addr, p_wbd);
      chk("t3 dirty latency", lat, 3);
      chk("t3 faddr", fetchAddress, 32'h0000_0200);
      repeat (4) @(negedge clk);

      // Reset in the middle of a write-back.
      ack_mode = 2;
      missValid = 1'b1; victimDirty = 1'b1;
      missAddress = 32'h0000_7000; victimAddress = 32'h0000_9000;
      victimData = pat_a;
      @(negedge clk);
      missValid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5 pre memReq", memReq, 1'b1);
      chk("t5 pre memWrite", memWrite, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("t5 memReq async", memReq, 1'b0);
      chk("t5 missReady", missReady, 1'b1);
      chk("t5 refillValid", refillValid, 1'b0);
      chk("t5 refillError", refillError, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Back-to-back misses with missValid held high.
      ack_mode = 1; rand_data = 1;
      missValid = 1'b1; victimDirty = 1'b0;
      missAddress = 32'h3000_0044;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) missAddress = 32'h4000_007F;
         if (k == 4) begin
            missValid = 1'b0;
            missAddress = 32'hDEAD_BEEF;
         end
         if (refillValid) begin
            rv_k.push_back(k);
            rv_a.push_back(fetchAddress);
         end
      end
      chk("t6 strobes", rv_k.size(), 2);
      if (rv_k.size() == 2) begin
         chk("t6 k0", rv_k[0], 2);
         chk("t6 a0", rv_a[0], 32'h3000_0040);
         chk("t6 k1", rv_k[1], 5);
         chk("t6 a1", rv_a[1], 32'h4000_0060);
      end

      // Random misses; the compare process checks every cycle.
      idle_noise = 1;
      for (int n = 0; n < 60; n++) begin
         ack_mode = ($urandom_range(7) == 0) ? 1 : 0;
         wb_dly = $urandom_range(6);
         rd_dly = $urandom_range(6);
         repeat ($urandom_range(3)) @(negedge clk);
         do_miss(1'($urandom), $urandom, $urandom, rnd_line(),
                 lat, err, p_req, p_wr, p_addr, p_wbd);
         chk("rnd no err", err, 1'b0);
      end
      ack_mode = 0;
      idle_noise = 0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
